// File: rtl/bnn_frame_io.sv
// Sequential wrapper around the combinational BNN classifier: collects a row-serial
// frame, holds it on layer_o, samples the scores after SETTLE cycles and emits the argmax.
module bnn_frame_io #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int NCLASS = 4,
  parameter int SW     = 7,
  parameter int SETTLE = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              row_valid_i,
  output logic                              row_ready_o,
  input  logic [COLS-1:0]                   row_data_i,
  output logic [0:0][ROWS-1:0][COLS-1:0]    layer_o,
  input  logic [NCLASS-1:0][SW-1:0]         layer_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [$clog2(NCLASS)-1:0]         res_class_o,
  output logic [SW-1:0]                     res_score_o,
  output logic [NCLASS-1:0][SW-1:0]         res_scores_o
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(NCLASS);

  typedef enum logic [1:0] {LOAD, WAIT, OUT} state_e;

  state_e                          state_q, state_d;
  logic [RW-1:0]                   row_cnt_q, row_cnt_d;
  logic [7:0]                      settle_q, settle_d;
  logic [0:0][ROWS-1:0][COLS-1:0]  layer_q;
  logic [NCLASS-1:0][SW-1:0]       scores_q;
  logic [CW-1:0]                   class_q, best_idx;
  logic [SW-1:0]                   score_q, best_score;
  logic                            accept, capture;

  // Linear signed compare chain; strict '>' keeps the lowest index on ties.
  always_comb begin
    best_idx   = '0;
    best_score = layer_i[0];
    for (int i = 1; i < NCLASS; i++) begin
      if ($signed(layer_i[i]) > $signed(best_score)) begin
        best_idx   = CW'(i);
        best_score = layer_i[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    settle_d    = settle_q;
    row_ready_o = 1'b0;
    res_valid_o = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state_q)
      LOAD: begin
        row_ready_o = 1'b1;
        if (row_valid_i) begin
          accept = 1'b1;
          if (row_cnt_q == RW'(ROWS-1)) begin
            state_d   = WAIT;
            row_cnt_d = '0;
            settle_d  = '0;
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
          end
        end
      end
      WAIT: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == 8'(SETTLE-1)) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= LOAD;
      row_cnt_q <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      settle_q  <= settle_d;
    end
  end

  // Frame rows persist until rewritten, so the classifier input stays stable through WAIT/OUT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      layer_q <= '0;
    end else if (accept) begin
      layer_q[0][row_cnt_q] <= row_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scores_q <= '0;
      class_q  <= '0;
      score_q  <= '0;
    end else if (capture) begin
      scores_q <= layer_i;
      class_q  <= best_idx;
      score_q  <= best_score;
    end
  end

  assign layer_o      = layer_q;
  assign res_scores_o = scores_q;
  assign res_class_o  = class_q;
  assign res_score_o  = score_q;

endmodule

// File: tb/tb_bnn_frame_io.sv
// Directed bench for bnn_frame_io: a timeline model predicts every output each cycle,
// and hand-computed literals pin the model for the documented scenarios.
module tb_bnn_frame_io;
  localparam int ROWS = 16, COLS = 16, NCLASS = 4, SW = 7, SETTLE = 4;
  localparam int CW = $clog2(NCLASS);

  logic clk = 1'b0, rst_n = 1'b0, row_valid = 1'b0, res_ready = 1'b0;
  logic [COLS-1:0]                row_data = '0;
  logic [NCLASS-1:0][SW-1:0]      scores = '0;
  logic                           row_ready_o, res_valid_o;
  logic [0:0][ROWS-1:0][COLS-1:0] layer_o;
  logic [CW-1:0]                  res_class_o;
  logic [SW-1:0]                  res_score_o;
  logic [NCLASS-1:0][SW-1:0]      res_scores_o;

  bnn_frame_io #(.ROWS(ROWS), .COLS(COLS), .NCLASS(NCLASS), .SW(SW), .SETTLE(SETTLE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .row_valid_i(row_valid), .row_ready_o(row_ready_o),
    .row_data_i(row_data), .layer_o(layer_o), .layer_i(scores), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready), .res_class_o(res_class_o), .res_score_o(res_score_o),
    .res_scores_o(res_scores_o));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0, last_edge = 0;
  int rise_q[$];
  logic prev_v = 1'b0;
  logic [COLS-1:0] fb [ROWS];
  logic [255:0] lit;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Timeline model: frame memory, rows-received count, settle countdown, result-pending flag.
  logic [COLS-1:0]           m_frame [ROWS];
  int                        m_row, m_wait, m_cls;
  bit                        m_load, m_out;
  logic [NCLASS-1:0][SW-1:0] m_scores;
  logic [SW-1:0]             m_score;
  logic [255:0]              mflat;

  task automatic model_argmax();
    int v, mx;
    mx = -(1 << 30);
    for (int i = 0; i < NCLASS; i++) begin
      v = $signed(m_scores[i]);
      if (v > mx) mx = v;
    end
    m_cls = -1;
    for (int i = 0; i < NCLASS; i++) begin
      v = $signed(m_scores[i]);
      if (v == mx && m_cls < 0) m_cls = i;
    end
    m_score = SW'(mx);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) m_frame[i] = '0;
      m_row = 0; m_wait = 0; m_load = 1; m_out = 0;
      m_scores = '0; m_cls = 0; m_score = '0;
    end else if (m_load) begin
      if (row_valid) begin
        m_frame[m_row] = row_data;
        m_row++;
        if (m_row == ROWS) begin m_row = 0; m_load = 0; m_wait = SETTLE; end
      end
    end else if (!m_out) begin
      m_wait--;
      if (m_wait == 0) begin m_scores = scores; model_argmax(); m_out = 1; end
    end else if (res_ready) begin
      m_out = 0; m_load = 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      mflat = '0;
      for (int r = 0; r < ROWS; r++) mflat[r*COLS +: COLS] = m_frame[r];
      chk("row_ready", row_ready_o, m_load);
      chk("res_valid", res_valid_o, m_out);
      chk("layer", layer_o, mflat);
      chk("res_class", res_class_o, m_cls[CW-1:0]);
      chk("res_score", res_score_o, m_score);
      chk("res_scores", res_scores_o, m_scores);
    end
    if (res_valid_o && !prev_v) rise_q.push_back(cyc);
    prev_v = res_valid_o;
  end

  task automatic set_sc(input int a, input int b, input int c, input int d);
    scores[0] = SW'(a); scores[1] = SW'(b); scores[2] = SW'(c); scores[3] = SW'(d);
  endtask

  task automatic send_row(input logic [COLS-1:0] d, input int gap);
    int t;
    repeat (gap) begin @(negedge clk); row_valid = 1'b0; end
    @(negedge clk);
    row_valid = 1'b1; row_data = d;
    t = 0;
    while (!row_ready_o && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin n_cmp++; n_bad++; $display("FAIL row_accept: timeout waiting for row_ready"); end
    @(posedge clk); #1;
    last_edge = cyc;
  endtask

  task automatic send_frame(input int max_gap, input bit drop);
    for (int r = 0; r < ROWS; r++) send_row(fb[r], $urandom_range(max_gap, 0));
    if (drop) begin @(negedge clk); row_valid = 1'b0; end
  endtask

  task automatic wait_result(input int hold, input bit wiggle);
    int t;
    t = 0;
    @(negedge clk);
    while (!res_valid_o && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin n_cmp++; n_bad++; $display("FAIL res_valid: timeout waiting for result"); end
    repeat (hold) begin
      if (wiggle) scores = (NCLASS*SW)'($urandom);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("ready_after_hs", row_ready_o, 1'b1);
  endtask

  task automatic chk_rows(input string nm);
    lit = '0;
    for (int r = 0; r < ROWS; r++) lit[r*COLS +: COLS] = fb[r];
    chk(nm, layer_o, lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // 1: mid-cycle reset and idle
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_layer", layer_o, '0);
    chk("rst_valid", res_valid_o, 1'b0);
    chk("rst_ready", row_ready_o, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_layer", layer_o, '0);
    chk("idle_valid", res_valid_o, 1'b0);

    // 2: identity frame, latency SETTLE from last beat
    rise_q.delete();
    set_sc(10, -3, 5, 2);
    for (int r = 0; r < ROWS; r++) fb[r] = COLS'(1) << r;
    send_frame(0, 1);
    wait_result(0, 0);
    chk_rows("identity");
    chk("basic_class", res_class_o, 2'd0);
    chk("basic_score", res_score_o, 7'd10);
    chk("latency", rise_q.size() > 0 ? rise_q[0] - last_edge : -1, SETTLE);

    // 3: tie picks lowest index; signed compare
    set_sc(3, 7, 7, -1);
    for (int r = 0; r < ROWS; r++) fb[r] = 16'h00FF;
    send_frame(0, 1);
    wait_result(0, 0);
    chk("tie_class", res_class_o, 2'd1);
    chk("tie_score", res_score_o, 7'd7);
    set_sc(-64, -2, -30, -5);
    send_frame(0, 1);
    wait_result(0, 0);
    chk("neg_class", res_class_o, 2'd1);
    chk("neg_score", res_score_o, 7'h7E);

    // 4: gaps, held result, layer_i wiggled while OUT
    set_sc(1, 2, 3, 4);
    for (int r = 0; r < ROWS; r++) fb[r] = COLS'($urandom);
    send_frame(5, 1);
    wait_result(20, 1);
    chk_rows("gap_frame");
    chk("hold_class", res_class_o, 2'd3);
    chk("hold_score", res_score_o, 7'd4);
    chk("hold_scores", res_scores_o, {7'd4, 7'd3, 7'd2, 7'd1});

    // 5: reset after 7 rows, then a clean frame
    for (int r = 0; r < 7; r++) send_row(16'hFFFF, 0);
    @(negedge clk); row_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("midrst_layer", layer_o, '0);
    @(negedge clk); rst_n = 1'b1;
    rise_q.delete();
    for (int r = 0; r < ROWS; r++) fb[r] = 16'hA5A5;
    send_frame(0, 1);
    wait_result(0, 0);
    repeat (8) @(negedge clk);
    chk_rows("a5_frame");
    chk("a5_results", rise_q.size(), 1);

    // 6: back-to-back frames with res_ready held high
    rise_q.delete();
    res_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) fb[r] = 16'h3C3C;
    send_frame(0, 0);
    for (int r = 0; r < ROWS; r++) fb[r] = 16'hC3C3;
    send_frame(0, 1);
    repeat (12) @(negedge clk);
    res_ready = 1'b0;
    chk("b2b_results", rise_q.size(), 2);
    chk("b2b_period", rise_q.size() > 1 ? rise_q[1] - rise_q[0] : -1, ROWS + SETTLE + 1);
    chk_rows("b2b_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
